// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
// Holds the datapath width, register-file geometry, the ALU pipeline latency,
// the ALU control codes and the sequencer FSM state encoding.
package alu_pkg;

  localparam int W       = 8;
  localparam int NREG    = 8;
  localparam int AW      = $clog2(NREG);
  localparam int ALU_LAT = 2;

  localparam logic [3:0] CTR_ADD = 4'b0000;
  localparam logic [3:0] CTR_SUB = 4'b0001;
  localparam logic [3:0] CTR_AND = 4'b1000;
  localparam logic [3:0] CTR_OR  = 4'b1001;
  localparam logic [3:0] CTR_XOR = 4'b1010;
  localparam logic [3:0] CTR_NOT = 4'b1011;
  localparam logic [3:0] CTR_SHR = 4'b1100;
  localparam logic [3:0] CTR_SHL = 4'b1101;
  localparam logic [3:0] CTR_ROR = 4'b1110;
  localparam logic [3:0] CTR_ROL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Bundle of every non-clock signal of the ALU sequencer.
//   op_*  : instruction handshake (valid/ready) and fields
//   alu_* : operand/control outputs to the ALU and its result input
//   ld_*  : side load port into the register file
//   res_* : writeback report (one-cycle pulse)
//   dbg_* : combinational debug read of the register file
// Modport slave is the sequencer's view; master is the surrounding system.
interface alu_seq_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    op_ctr;
  logic [AW-1:0] op_rd;
  logic [AW-1:0] op_rs1;
  logic [AW-1:0] op_rs2;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [3:0]    alu_ctr;
  logic [W-1:0]  alu_o;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          res_valid;
  logic [AW-1:0] res_rd;
  logic [W-1:0]  res_data;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  modport slave (
    input  op_valid, op_ctr, op_rd, op_rs1, op_rs2, alu_o,
           ld_en, ld_addr, ld_data, dbg_addr,
    output op_ready, alu_a, alu_b, alu_ctr, res_valid, res_rd, res_data,
           dbg_data
  );

  modport master (
    output op_valid, op_ctr, op_rd, op_rs1, op_rs2, alu_o,
           ld_en, ld_addr, ld_data, dbg_addr,
    input  op_ready, alu_a, alu_b, alu_ctr, res_valid, res_rd, res_data,
           dbg_data
  );
endinterface

// File: rtl/alu_seq_rf.sv
// NREG x W register file with asynchronous reset to zero.
//   ck, rst_n           : clock, asynchronous active-low reset
//   wb_en/addr/data     : ALU writeback
//   ld_en/addr/data     : side load
//   rs1/rs2_addr, data  : combinational operand reads
//   dbg_addr, dbg_data  : combinational debug read
// Writeback and load may both land on the same edge; when they target the
// same register the writeback value is kept, otherwise both are written.
module alu_seq_rf #(
  parameter int W    = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic [AW-1:0] rs1_addr,
  output logic [W-1:0]  rs1_data,
  input  logic [AW-1:0] rs2_addr,
  output logic [W-1:0]  rs2_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] rf_q [NREG];
  logic [W-1:0] rf_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
      if (wb_en && (wb_addr == AW'(i))) begin
        rf_d[i] = wb_data;
      end else if (ld_en && (ld_addr == AW'(i))) begin
        rf_d[i] = ld_data;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  assign rs1_data = rf_q[rs1_addr];
  assign rs2_data = rf_q[rs2_addr];
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// Operation sequencer in front of a registered ALU with ALU_LAT cycles of
// latency. Accepts one instruction per valid/ready handshake, drives the ALU
// with the two source registers and the control code, waits out the ALU
// latency and writes the result back to the destination register.
//   ck, rst_n : clock, asynchronous active-low reset
//   bus       : alu_seq_if slave (op handshake, ALU drive/result, load port,
//               writeback report, debug read)
// Throughput is one instruction per four cycles with ALU_LAT = 2.
module alu_seq #(
  parameter int W       = alu_pkg::W,
  parameter int NREG    = alu_pkg::NREG,
  parameter int ALU_LAT = alu_pkg::ALU_LAT
) (
  input  logic     ck,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  import alu_pkg::*;

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(ALU_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [3:0]    alu_ctr_q, alu_ctr_d;
  logic          res_valid_q, res_valid_d;
  logic [AW-1:0] res_rd_q, res_rd_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic [W-1:0]  rs1_data, rs2_data;
  logic          wb_en;

  assign wb_en = (state_q == ST_WB);

  alu_seq_rf #(.W(W), .NREG(NREG), .AW(AW)) u_rf (
    .ck       (ck),
    .rst_n    (rst_n),
    .wb_en    (wb_en),
    .wb_addr  (rd_q),
    .wb_data  (bus.alu_o),
    .ld_en    (bus.ld_en),
    .ld_addr  (bus.ld_addr),
    .ld_data  (bus.ld_data),
    .rs1_addr (bus.op_rs1),
    .rs1_data (rs1_data),
    .rs2_addr (bus.op_rs2),
    .rs2_data (rs2_data),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctr_d   = alu_ctr_q;
    res_valid_d = 1'b0;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;
    case (state_q)
      ST_IDLE: begin
        // Operands come from the pre-edge register contents, so a load on
        // the accept edge is deliberately not forwarded.
        if (bus.op_valid) begin
          alu_a_d   = rs1_data;
          alu_b_d   = rs2_data;
          alu_ctr_d = bus.op_ctr;
          rd_d      = bus.op_rd;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Leave on the edge where the counter reaches zero; a counter
        // already at zero (ALU_LAT = 1) also leaves.
        if (cnt_q <= CW'(1)) begin
          state_d = ST_WB;
        end
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      end
      ST_WB: begin
        res_valid_d = 1'b1;
        res_rd_d    = rd_q;
        res_data_d  = bus.alu_o;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctr_q   <= '0;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctr_q   <= alu_ctr_d;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
    end
  end

  // Gated with rst_n so the block never advertises readiness while held
  // in reset, yet is ready immediately after release.
  assign bus.op_ready  = rst_n && (state_q == ST_IDLE);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_ctr   = alu_ctr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_rd    = res_rd_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a two-stage ALU model closes the loop,
// expected writebacks are queued when an op is presented and compared when
// res_valid pulses.
module tb_alu_seq;
  import alu_pkg::*;

  logic ck = 1'b0;
  logic rst_n;
  always #5 ck = ~ck;

  alu_seq_if #(.W(8), .AW(3)) bus ();

  alu_seq dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_rf [8];
  int         total = 0;
  int         bad = 0;
  int         wb_cnt = 0;
  int         exp_cnt = 0;
  logic [7:0] alu_s1;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] c);
    case (c)
      CTR_ADD: return a + b;
      CTR_SUB: return a - b;
      CTR_AND: return a & b;
      CTR_OR:  return a | b;
      CTR_XOR: return a ^ b;
      CTR_NOT: return ~a;
      CTR_SHR: return a >> 1;
      CTR_SHL: return a << 1;
      CTR_ROR: return {a[0], a[7:1]};
      CTR_ROL: return {a[6:0], a[7]};
      default: return 8'h00;
    endcase
  endfunction

  // External ALU: inputs sampled on one edge, result registered on the next.
  always @(posedge ck) begin
    alu_s1    <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctr);
    bus.alu_o <= alu_s1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Writeback monitor, sampled 2 time units after each rising edge.
  always begin
    exp_t e;
    @(posedge ck);
    #2;
    if (bus.res_valid) begin
      wb_cnt++;
      if (sb.size() == 0) begin
        chk_eq("wb_unexpected", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        $display("wb  rd=%0d data=%02h (want rd=%0d data=%02h)", bus.res_rd, bus.res_data, e.rd, e.data);
        chk_eq("res_rd", bus.res_rd, e.rd);
        chk_eq("res_data", bus.res_data, e.data);
        ref_rf[e.rd] = e.data;
      end
    end
  end

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    ref_rf[a]   = d;
    @(posedge ck);
    #1;
    bus.ld_en = 1'b0;
  endtask

  task automatic chk_reg(input logic [2:0] a, input logic [7:0] want);
    @(negedge ck);
    bus.dbg_addr = a;
    #1;
    chk_eq($sformatf("dbg_r%0d", a), bus.dbg_data, want);
  endtask

  // Presents an op and returns just before its accept edge; n is the number
  // of cycles spent waiting for op_ready.
  task automatic present(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, output int n);
    exp_t e;
    bus.op_ctr   = c;
    bus.op_rd    = rd;
    bus.op_rs1   = rs1;
    bus.op_rs2   = rs2;
    bus.op_valid = 1'b1;
    n = 0;
    while (!bus.op_ready && n < 20) begin
      tick();
      n++;
    end
    chk_eq("ready_wait", bus.op_ready, 1);
    #2;
    e.rd   = rd;
    e.data = alu_fn(ref_rf[rs1], ref_rf[rs2], c);
    sb.push_back(e);
    exp_cnt++;
    $display("op  ctr=%04b rd=%0d rs1=%0d rs2=%0d want=%02h", c, rd, rs1, rs2, e.data);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.op_ready && n < 20) begin
      tick();
      n++;
    end
    chk_eq("idle_wait", bus.op_ready, 1);
  endtask

  task automatic run_op(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2);
    int n;
    present(c, rd, rs1, rs2, n);
    tick();
    bus.op_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    int cnt0;
    bus.op_valid = 1'b0;
    bus.op_ctr   = '0;
    bus.op_rd    = '0;
    bus.op_rs1   = '0;
    bus.op_rs2   = '0;
    bus.ld_en    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.dbg_addr = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
    rst_n = 1'b0;

    // Reset state
    repeat (2) tick();
    chk_eq("rst_ready", bus.op_ready, 0);
    chk_eq("rst_alu_a", bus.alu_a, 0);
    chk_eq("rst_alu_b", bus.alu_b, 0);
    chk_eq("rst_alu_ctr", bus.alu_ctr, 0);
    chk_eq("rst_res_valid", bus.res_valid, 0);
    chk_eq("rst_res_rd", bus.res_rd, 0);
    chk_eq("rst_res_data", bus.res_data, 0);
    rst_n = 1'b1;
    #1;
    chk_eq("rel_ready", bus.op_ready, 1);

    // Basic ADD with exact writeback timing
    load(3'd1, 8'h3C);
    load(3'd2, 8'h0A);
    present(CTR_ADD, 3'd3, 3'd1, 3'd2, n);
    tick();
    bus.op_valid = 1'b0;
    chk_eq("issue_alu_a", bus.alu_a, 8'h3C);
    chk_eq("issue_alu_b", bus.alu_b, 8'h0A);
    chk_eq("issue_alu_ctr", bus.alu_ctr, CTR_ADD);
    chk_eq("issue_ready", bus.op_ready, 0);
    tick();
    chk_eq("e1_res_valid", bus.res_valid, 0);
    tick();
    chk_eq("e2_res_valid", bus.res_valid, 0);
    tick();
    chk_eq("e3_res_valid", bus.res_valid, 1);
    chk_eq("e3_res_rd", bus.res_rd, 3);
    chk_eq("e3_res_data", bus.res_data, 8'h46);
    tick();
    chk_eq("e4_res_valid", bus.res_valid, 0);
    chk_eq("hold_alu_a", bus.alu_a, 8'h3C);
    chk_reg(3'd3, 8'h46);

    // Load colliding with writeback to the same register
    present(CTR_ADD, 3'd3, 3'd1, 3'd2, n);
    tick();
    bus.op_valid = 1'b0;
    tick();
    tick();
    bus.ld_en   = 1'b1;
    bus.ld_addr = 3'd3;
    bus.ld_data = 8'hAA;
    ref_rf[3]   = 8'hAA;
    tick();
    bus.ld_en = 1'b0;
    chk_reg(3'd3, 8'h46);

    // Load at the accept edge is not forwarded
    present(CTR_ADD, 3'd5, 3'd2, 3'd2, n);
    bus.ld_en   = 1'b1;
    bus.ld_addr = 3'd2;
    bus.ld_data = 8'h11;
    ref_rf[2]   = 8'h11;
    tick();
    bus.ld_en    = 1'b0;
    bus.op_valid = 1'b0;
    chk_eq("nofwd_alu_b", bus.alu_b, 8'h0A);
    wait_idle();
    chk_reg(3'd5, 8'h14);
    chk_reg(3'd2, 8'h11);

    // Wrap and shift/rotate
    load(3'd1, 8'h05);
    load(3'd2, 8'h07);
    run_op(CTR_SUB, 3'd4, 3'd1, 3'd2);
    chk_reg(3'd4, 8'hFE);
    load(3'd5, 8'h81);
    run_op(CTR_ROR, 3'd6, 3'd5, 3'd0);
    chk_reg(3'd6, 8'hC0);
    run_op(CTR_SHL, 3'd7, 3'd5, 3'd0);
    chk_reg(3'd7, 8'h02);

    // Back-to-back with op_valid held high
    cnt0 = wb_cnt;
    present(CTR_XOR, 3'd1, 3'd5, 3'd4, n);
    tick();
    present(CTR_OR, 3'd0, 3'd1, 3'd5, n);
    chk_eq("b2b_wait", n, 3);
    tick();
    bus.op_valid = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk_eq("b2b_pulses", wb_cnt - cnt0, 2);
    chk_reg(3'd1, 8'h7F);
    chk_reg(3'd0, 8'hFF);

    // Undefined control code and rs1 = rs2 = rd
    run_op(4'b0101, 3'd6, 3'd1, 3'd2);
    chk_reg(3'd6, 8'h00);
    run_op(CTR_ADD, 3'd2, 3'd2, 3'd2);
    chk_reg(3'd2, 8'h0E);

    // Reset in WAIT aborts the op
    present(CTR_ADD, 3'd3, 3'd1, 3'd2, n);
    tick();
    bus.op_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    exp_cnt -= sb.size();
    sb.delete();
    for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
    chk_eq("midrst_ready", bus.op_ready, 0);
    chk_eq("midrst_alu_a", bus.alu_a, 0);
    chk_eq("midrst_res_valid", bus.res_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk_eq("midrel_ready", bus.op_ready, 1);
    for (int i = 0; i < 8; i++) chk_reg(3'(i), ref_rf[i]);
    repeat (4) tick();
    chk_eq("wb_total", wb_cnt, exp_cnt);
    chk_eq("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
